// File: rtl/bcd_pkg.sv
// Shared BCD helpers and constants for the counter, display and decoder blocks.
package bcd_pkg;

   localparam logic [3:0] BCD_BLANK      = 4'hF;
   localparam logic [3:0] BCD_NINE       = 4'd9;
   localparam int         BCD_MAX_DIGITS = 8;

   // Converts a non-negative decimal integer to packed BCD, digit 0 in [3:0].
   function automatic logic [31:0] int_to_bcd(input int value, input int digits);
      logic [31:0] res;
      int          v;
      res = 32'h0;
      v   = value;
      for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
         if (i < digits) begin
            res[4*i +: 4] = 4'(v % 10);
            v             = v / 10;
         end else begin
            res[4*i +: 4] = 4'h0;
         end
      end
      return res;
   endfunction

   // True when every nibble holds a legal decimal digit.
   function automatic logic bcd_valid(input logic [31:0] vec);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
         if (vec[4*i +: 4] > BCD_NINE) begin
            ok = 1'b0;
         end else begin
            ok = ok;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: steps a single digit and ripples carry or borrow
// to the next decade.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       inc,
   input  logic       dec,
   input  logic       carry_in,
   input  logic       borrow_in,
   output logic [3:0] next_digit,
   output logic       carry_out,
   output logic       borrow_out
);

   // Next digit value for one step in the requested direction.
   always_comb begin
      next_digit = digit;
      carry_out  = 1'b0;
      borrow_out = 1'b0;
      if (inc && carry_in) begin
         if (digit >= BCD_NINE) begin
            next_digit = 4'd0;
            carry_out  = 1'b1;
         end else begin
            next_digit = digit + 4'd1;
         end
      end else if (dec && borrow_in) begin
         if (digit == 4'd0) begin
            next_digit = BCD_NINE;
            borrow_out = 1'b1;
         end else begin
            next_digit = digit - 4'd1;
         end
      end else begin
         next_digit = digit;
      end
   end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with programmable range, checked parallel load,
// wrap pulse and leading-zero blanking for 7-segment decoders.
module bcd_counter_n
   import bcd_pkg::*;
#(
   parameter int DIGITS    = 2,
   parameter int MIN_VAL   = 1,
   parameter int MAX_VAL   = 99,
   parameter int RESET_VAL = 1,
   parameter int BLANK_LZ  = 1
)(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                en,
   input  logic                up,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] count,
   output logic [4*DIGITS-1:0] disp,
   output logic                wrap,
   output logic                load_err
);

   localparam int           W         = 4 * DIGITS;
   localparam logic [W-1:0] MIN_BCD   = W'(int_to_bcd(MIN_VAL, DIGITS));
   localparam logic [W-1:0] MAX_BCD   = W'(int_to_bcd(MAX_VAL, DIGITS));
   localparam logic [W-1:0] RESET_BCD = W'(int_to_bcd(RESET_VAL, DIGITS));

   if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS || MIN_VAL < 0 || MIN_VAL > MAX_VAL ||
       MAX_VAL >= 10**DIGITS || RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_bad_param
      $error("bcd_counter_n: illegal DIGITS/MIN_VAL/MAX_VAL/RESET_VAL combination");
   end

   logic [W-1:0]    count_r;
   logic            wrap_r;
   logic            load_err_r;
   logic [W-1:0]    count_nxt_s;
   logic            wrap_nxt_s;
   logic            load_err_nxt_s;
   logic [W-1:0]    step_s;
   logic [DIGITS:0] carry_s;
   logic [DIGITS:0] borrow_s;
   logic            unused_chain_s;
   logic            ge_min_s;
   logic            load_ok_s;
   logic [W-1:0]    disp_s;

   assign carry_s[0]     = 1'b1;
   assign borrow_s[0]    = 1'b1;
   assign unused_chain_s = carry_s[DIGITS] ^ borrow_s[DIGITS];

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .digit      (count_r[4*i +: 4]),
         .inc        (up),
         .dec        (~up),
         .carry_in   (carry_s[i]),
         .borrow_in  (borrow_s[i]),
         .next_digit (step_s[4*i +: 4]),
         .carry_out  (carry_s[i+1]),
         .borrow_out (borrow_s[i+1])
      );
   end

   // Digits are all <= 9 here, so packed-vector order equals decimal order.
   if (MIN_VAL == 0) begin : g_min_zero
      assign ge_min_s = 1'b1;
   end else begin : g_min_cmp
      assign ge_min_s = (load_val >= MIN_BCD);
   end

   assign load_ok_s = bcd_valid(32'(load_val)) && ge_min_s && (load_val <= MAX_BCD);

   // Next count, wrap and load-error; load outranks counting.
   always_comb begin
      count_nxt_s    = count_r;
      wrap_nxt_s     = 1'b0;
      load_err_nxt_s = 1'b0;
      if (load) begin
         if (load_ok_s) begin
            count_nxt_s = load_val;
         end else begin
            load_err_nxt_s = 1'b1;
         end
      end else if (en) begin
         if (up && (count_r == MAX_BCD)) begin
            count_nxt_s = MIN_BCD;
            wrap_nxt_s  = 1'b1;
         end else if (!up && (count_r == MIN_BCD)) begin
            count_nxt_s = MAX_BCD;
            wrap_nxt_s  = 1'b1;
         end else begin
            count_nxt_s = step_s;
         end
      end else begin
         count_nxt_s = count_r;
      end
   end

   // State registers with immediate asynchronous reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_r    <= RESET_BCD;
         wrap_r     <= 1'b0;
         load_err_r <= 1'b0;
      end else begin
         count_r    <= count_nxt_s;
         wrap_r     <= wrap_nxt_s;
         load_err_r <= load_err_nxt_s;
      end
   end

   // Leading-zero blanking; digit 0 always shows so zero reads as "0".
   always_comb begin
      logic lead_zero;
      disp_s    = count_r;
      lead_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         lead_zero = lead_zero && (count_r[4*i +: 4] == 4'h0);
         if (lead_zero && (BLANK_LZ != 0)) begin
            disp_s[4*i +: 4] = BCD_BLANK;
         end else begin
            disp_s[4*i +: 4] = count_r[4*i +: 4];
         end
      end
   end

   assign count    = count_r;
   assign disp     = disp_s;
   assign wrap     = wrap_r;
   assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench: a default 2-digit counter and a 4-digit 0..9999 counter,
// driven from a vector table through an expected-value queue.
module tb_bcd_counter_n;

   typedef struct {
      int          idx;
      bit          sel;
      logic        en;
      logic        up;
      logic        load;
      logic [15:0] load_val;
      logic [15:0] exp_count;
      logic [15:0] exp_disp;
      logic        exp_wrap;
      logic        exp_err;
   } vec_t;

   logic        clock;
   logic        reset_n;
   logic        a_en, a_up, a_load;
   logic [7:0]  a_load_val, a_count, a_disp;
   logic        a_wrap, a_load_err;
   logic        b_en, b_up, b_load;
   logic [15:0] b_load_val, b_count, b_disp;
   logic        b_wrap, b_load_err;

   int   checks;
   int   errors;
   vec_t tab[$];
   vec_t sb_q[$];

   bcd_counter_n u_dut_a (
      .clock    (clock),
      .reset_n  (reset_n),
      .en       (a_en),
      .up       (a_up),
      .load     (a_load),
      .load_val (a_load_val),
      .count    (a_count),
      .disp     (a_disp),
      .wrap     (a_wrap),
      .load_err (a_load_err)
   );

   bcd_counter_n #(
      .DIGITS(4), .MIN_VAL(0), .MAX_VAL(9999), .RESET_VAL(0), .BLANK_LZ(1)
   ) u_dut_b (
      .clock    (clock),
      .reset_n  (reset_n),
      .en       (b_en),
      .up       (b_up),
      .load     (b_load),
      .load_val (b_load_val),
      .count    (b_count),
      .disp     (b_disp),
      .wrap     (b_wrap),
      .load_err (b_load_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit sel, input logic en, input logic up, input logic load,
                               input logic [15:0] lv, input logic [15:0] ec,
                               input logic [15:0] ed, input logic ew, input logic ee);
      vec_t v;
      v.idx = 0; v.sel = sel; v.en = en; v.up = up; v.load = load; v.load_val = lv;
      v.exp_count = ec; v.exp_disp = ed; v.exp_wrap = ew; v.exp_err = ee;
      return v;
   endfunction

   task automatic idle_inputs();
      a_en = 1'b0; a_up = 1'b0; a_load = 1'b0; a_load_val = 8'h00;
      b_en = 1'b0; b_up = 1'b0; b_load = 1'b0; b_load_val = 16'h0000;
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      @(negedge clock);
      idle_inputs();
      if (v.sel) begin
         b_en = v.en; b_up = v.up; b_load = v.load; b_load_val = v.load_val;
      end else begin
         a_en = v.en; a_up = v.up; a_load = v.load; a_load_val = v.load_val[7:0];
      end
      sb_q.push_back(v);
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
         chk("scoreboard empty", 16'h0001, 16'h0000);
      end else begin
         e = sb_q.pop_front();
         if (e.sel) begin
            chk($sformatf("B vec%0d count", e.idx), b_count, e.exp_count);
            chk($sformatf("B vec%0d disp", e.idx), b_disp, e.exp_disp);
            chk($sformatf("B vec%0d wrap", e.idx), {15'h0, b_wrap}, {15'h0, e.exp_wrap});
            chk($sformatf("B vec%0d load_err", e.idx), {15'h0, b_load_err}, {15'h0, e.exp_err});
         end else begin
            chk($sformatf("A vec%0d count", e.idx), {8'h00, a_count}, e.exp_count);
            chk($sformatf("A vec%0d disp", e.idx), {8'h00, a_disp}, e.exp_disp);
            chk($sformatf("A vec%0d wrap", e.idx), {15'h0, a_wrap}, {15'h0, e.exp_wrap});
            chk($sformatf("A vec%0d load_err", e.idx), {15'h0, a_load_err}, {15'h0, e.exp_err});
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle_inputs();
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      chk("A reset count", {8'h00, a_count}, 16'h0001);
      chk("A reset disp", {8'h00, a_disp}, 16'h00F1);
      chk("A reset wrap", {15'h0, a_wrap}, 16'h0000);
      chk("A reset load_err", {15'h0, a_load_err}, 16'h0000);
      chk("B reset count", b_count, 16'h0000);
      chk("B reset disp", b_disp, 16'hFFF0);
      @(negedge clock);
      reset_n = 1'b1;

      //          sel   en    up    load  load_val  count     disp      wrap  err
      tab.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0009, 16'h0009, 16'h00F9, 1'b0, 1'b0));
      tab.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0010, 1'b0, 1'b0));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0009, 16'h00F9, 1'b0, 1'b0));
      tab.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0099, 16'h0099, 16'h0099, 1'b0, 1'b0));
      tab.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'h00F1, 1'b1, 1'b0));
      tab.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'h00F1, 1'b0, 1'b0));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0099, 16'h0099, 1'b1, 1'b0));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0098, 16'h0098, 1'b0, 1'b0));
      tab.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h0057, 16'h0057, 16'h0057, 1'b0, 1'b0));
      tab.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h005A, 16'h0057, 16'h0057, 1'b0, 1'b1));
      tab.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0057, 16'h0057, 1'b0, 1'b0));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0057, 16'h0057, 1'b0, 1'b1));
      tab.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h00A1, 16'h0057, 16'h0057, 1'b0, 1'b1));
      tab.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0042, 16'h0042, 16'h0042, 1'b0, 1'b0));
      tab.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0099, 16'h0099, 16'hFF99, 1'b0, 1'b0));
      tab.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'hF100, 1'b0, 1'b0));
      tab.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFF0, 1'b0, 1'b0));
      tab.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0));
      tab.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFF0, 1'b1, 1'b0));
      tab.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFF0, 1'b0, 1'b0));
      tab.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h1A00, 16'h0000, 16'hFFF0, 1'b0, 1'b1));
      tab.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFF1, 1'b0, 1'b0));
      tab.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0909, 16'h0909, 16'hF909, 1'b0, 1'b0));
      tab.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0908, 16'hF908, 1'b0, 1'b0));

      for (int i = 0; i < tab.size(); i++) begin
         vec_t v;
         v     = tab[i];
         v.idx = i;
         step(v);
      end

      // Counter A holds 42; reset is pulsed between edges with en high.
      @(negedge clock);
      idle_inputs();
      a_en = 1'b1;
      a_up = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      chk("A async reset count", {8'h00, a_count}, 16'h0001);
      chk("A async reset disp", {8'h00, a_disp}, 16'h00F1);
      reset_n = 1'b1;
      #1;
      chk("A count after release", {8'h00, a_count}, 16'h0001);
      @(posedge clock);
      #1;
      chk("A first step after reset", {8'h00, a_count}, 16'h0002);
      chk("A wrap after reset step", {15'h0, a_wrap}, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
